// File: rtl/run_event_logger.sv
// Turns each q-high episode into a {type, duration} record queued in a small FIFO.
// Optional RUN_DROP_CNT_EN adds a saturating drop_cnt output.
module run_event_logger #(
  parameter int DUR_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    w,
  input  logic                    q,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [DUR_W:0]          ev_data,
  output logic [$clog2(DEPTH):0]  ev_level
`ifdef RUN_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             q_d;
  logic             w_d;
  logic             rise;
  logic             fall;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             drop;
  logic [DUR_W-1:0] dur;
  logic             run_type;
  logic [DUR_W:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A rise while in RUN cannot come from the detector and is ignored
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (rise) state_nxt = RUN;
      RUN:  if (fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push = 1'b0;
    unique case (state)
      IDLE: push = 1'b0;
      RUN:  push = fall;
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      q_d      <= 1'b0;
      w_d      <= 1'b0;
      dur      <= '0;
      run_type <= 1'b0;
    end else begin
      q_d <= q;
      w_d <= w;
      if (state == IDLE && rise) begin
        dur      <= DUR_W'(1);
        run_type <= w_d;
      end else if (state == RUN && q && dur != '1) begin
        dur <= dur + 1'b1;
      end
    end
  end

  assign pop   = ev_valid & ev_ready;
  assign full  = (level == (AW+1)'(DEPTH));
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (!Reset && wr_en) begin
      mem[wr_ptr] <= {run_type, dur};
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Gate the head so an empty FIFO shows zeros rather than stale storage
  assign ev_valid = (level != '0);
  assign ev_data  = ev_valid ? mem[rd_ptr] : '0;
  assign ev_level = level;

`ifdef RUN_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_run_event_logger.sv
// Directed bench for run_event_logger: reset, capture, saturation,
// FIFO overflow, full push+pop and mid-run reset.
module tb_run_event_logger;

  localparam int DUR_W = 8;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           Reset;
  logic           w;
  logic           q;
  logic           ev_valid;
  logic           ev_ready;
  logic [DUR_W:0] ev_data;
  logic [2:0]     ev_level;
`ifdef RUN_DROP_CNT_EN
  logic [7:0]     drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  run_event_logger #(
    .DUR_W(DUR_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .w        (w),
    .q        (q),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_data  (ev_data),
    .ev_level (ev_level)
`ifdef RUN_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic cyc(input logic wv, input logic qv, input logic rv);
    w        = wv;
    q        = qv;
    ev_ready = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pre-cycle sets w_d to the run type, then len q-high cycles, then the fall
  task automatic run(input logic t, input int len);
    cyc(t, 1'b0, 1'b0);
    repeat (len) cyc(t, 1'b1, 1'b0);
    cyc(t, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rec(input logic t, input int d);
    logic [7:0] d8;
    d8 = d[7:0];
    return {23'b0, t, d8};
  endfunction

  task automatic pop_chk(input string tag, input logic [31:0] e);
    chk({tag, "_valid"}, {31'b0, ev_valid}, 32'd1);
    chk({tag, "_data"}, {23'b0, ev_data}, e);
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    Reset    = 1'b1;
    w        = 1'b1;
    q        = 1'b1;
    ev_ready = 1'b0;

    // T1: reset held with q high
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t1_rst_valid", {31'b0, ev_valid}, 32'd0);
    chk("t1_rst_level", {29'b0, ev_level}, 32'd0);
    chk("t1_rst_data", {23'b0, ev_data}, 32'd0);
`ifdef RUN_DROP_CNT_EN
    chk("t1_rst_drop", {24'b0, drop_cnt}, 32'd0);
`endif
    Reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t1_no_rec", {31'b0, ev_valid}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t1_level", {29'b0, ev_level}, 32'd1);
    pop_chk("t1_rec", rec(1'b0, 2));
    chk("t1_empty", {29'b0, ev_level}, 32'd0);

    // T2: zeros run, 3 cycles, sink always ready
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    chk("t2_pre_fall", {31'b0, ev_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t2_valid", {31'b0, ev_valid}, 32'd1);
    chk("t2_data", {23'b0, ev_data}, rec(1'b0, 3));
    cyc(1'b0, 1'b0, 1'b1);
    chk("t2_popped", {31'b0, ev_valid}, 32'd0);

    // T3: long ones runs, one just under and one past saturation
    run(1'b1, 254);
    pop_chk("t3_254", rec(1'b1, 254));
    run(1'b1, 300);
    chk("t3_level", {29'b0, ev_level}, 32'd1);
    pop_chk("t3_sat", rec(1'b1, 255));

    // T4: overflow with sink stalled
    run(1'b0, 2);
    run(1'b1, 2);
    run(1'b0, 3);
    run(1'b1, 4);
    chk("t4_full", {29'b0, ev_level}, 32'd4);
    run(1'b1, 7);
    chk("t4_full_after", {29'b0, ev_level}, 32'd4);
`ifdef RUN_DROP_CNT_EN
    chk("t4_drop", {24'b0, drop_cnt}, 32'd1);
`endif
    pop_chk("t4_r0", rec(1'b0, 2));
    pop_chk("t4_r1", rec(1'b1, 2));
    pop_chk("t4_r2", rec(1'b0, 3));
    pop_chk("t4_r3", rec(1'b1, 4));
    chk("t4_drained", {31'b0, ev_valid}, 32'd0);

    // T5: push on full coincides with pop
    run(1'b0, 2);
    run(1'b1, 3);
    run(1'b0, 4);
    run(1'b1, 5);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t5_level", {29'b0, ev_level}, 32'd4);
`ifdef RUN_DROP_CNT_EN
    chk("t5_drop", {24'b0, drop_cnt}, 32'd1);
`endif
    pop_chk("t5_r0", rec(1'b1, 3));
    pop_chk("t5_r1", rec(1'b0, 4));
    pop_chk("t5_r2", rec(1'b1, 5));
    pop_chk("t5_r3", rec(1'b0, 6));
    chk("t5_drained", {29'b0, ev_level}, 32'd0);

    // T6: reset mid-run with a record already stored
    run(1'b0, 3);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    Reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    Reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("t6_lost", {29'b0, ev_level}, 32'd0);
    chk("t6_no_valid", {31'b0, ev_valid}, 32'd0);
`ifdef RUN_DROP_CNT_EN
    chk("t6_drop_clr", {24'b0, drop_cnt}, 32'd0);
`endif
    run(1'b1, 2);
    chk("t6_level", {29'b0, ev_level}, 32'd1);
    pop_chk("t6_rec", rec(1'b1, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
